ps2_packet_assembler: RTL
=========================

// Module: ps2_packet_assembler
// PURPOSE
//  Upstream stage of the mouse magnitude arithmetic. Consumes the byte stream from the
//  PS/2 receiver and assembles standard 3-byte mouse packets. Emits registered 9-bit
//  two's-complement x_axis/y_axis, buttons and overflow flags, with a one-cycle strobe
//  per complete packet. Resynchronises on a bad header byte and on an inter-byte timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  50000  max clk cycles allowed between bytes of one packet (>=2)
// PORTS
//  clk           in   1  single system clock; all logic on rising edge
//  rst           in   1  synchronous, active-high reset
//  rx_data       in   8  received PS/2 byte
//  rx_valid      in   1  1-cycle strobe: rx_data valid this cycle
//  x_axis        out  9  {byte0[4], byte1}, two's complement
//  y_axis        out  9  {byte0[5], byte2}, two's complement
//  buttons       out  3  byte0[2:0] = {middle, right, left}
//  x_ovf         out  1  byte0[6]
//  y_ovf         out  1  byte0[7]
//  packet_valid  out  1  1-cycle strobe: outputs updated with a new packet
//  sync_err      out  1  1-cycle strobe: header byte rejected (bit3 == 0)
//  timeout       out  1  1-cycle strobe: partial packet dropped on timeout
// BEHAVIOUR
//  - Reset: state=WAIT_B0, timer=0; all outputs 0.
//  - FSM: WAIT_B0 -> WAIT_B1 -> WAIT_B2 -> WAIT_B0. Advances only on rx_valid.
//  - WAIT_B0 + rx_valid:
//    - rx_data[3]==1: latch byte0, go WAIT_B1.
//    - Else: discard, stay WAIT_B0, sync_err=1 next cycle.
//  - WAIT_B1 + rx_valid: latch byte1, go WAIT_B2.
//  - WAIT_B2 + rx_valid: go WAIT_B0; next cycle packet_valid=1 and x_axis, y_axis,
//    buttons, x_ovf, y_ovf all update together.
//  - Outputs hold between packets. Strobes last exactly 1 cycle.
//  - Latency: last-byte rx_valid to packet_valid = 1 clk.
//  - Back-to-back rx_valid on consecutive cycles is accepted.
//  - Timer, width $clog2(TIMEOUT_CYCLES):
//    - Cleared on every rx_valid and in WAIT_B0.
//    - Otherwise increments while in WAIT_B1/WAIT_B2.
//    - On reaching TIMEOUT_CYCLES-1: go WAIT_B0, timeout=1 next cycle, partial bytes dropped.
//  - Simultaneous rx_valid and timer expiry: rx_valid wins; byte accepted, timer cleared,
//    no timeout.
//  - Reset mid-packet discards partial bytes; no strobe is emitted.
//  - Arithmetic: bit concatenation only. Sign bits come from byte0; no sign extension
//    beyond 9 bits.
// CONFIGURATION
//  PS2_OVF_SAT_EN defined:
//    - Axis with its ovf bit set outputs saturated value:
//      sign=0 -> 9'h0FF (+255); sign=1 -> 9'h100 (-256).
//    - Flags still reported.
//  PS2_OVF_SAT_EN undefined: raw {sign, byte} always output; flags informational only.
// TESTING
//  - Bytes 28,10,F0 -> packet_valid 1 clk after F0; x=010, y=1F0, buttons=0, ovf=0.
//  - Byte 00 in WAIT_B0 -> sync_err pulse, no packet. Then 09,01,02 -> x=001, y=002,
//    buttons=001.
//  - 08,01, then idle TIMEOUT_CYCLES clks -> single timeout pulse, no packet. Then
//    08,03,04 -> x=003, y=004.
//  - 58,12,00:
//    - Macro on: x=100, y=000, x_ovf=1.
//    - Macro off: x=112, x_ovf=1.
//  - rst asserted after 08,01 -> all outputs 0. Then 08,05,06 -> x=005, y=006, one
//    packet_valid.
//  - Byte arriving on the exact expiry cycle is accepted; no timeout pulse.

Source files
------------

// File: rtl/ps2_packet_assembler_if.sv
// PS/2 byte stream into the packet assembler and the assembled mouse packet out of it.
// The receiver side drives master; the assembler attaches as slave.
interface ps2_packet_assembler_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [8:0] x_axis;
  logic [8:0] y_axis;
  logic [2:0] buttons;
  logic       x_ovf;
  logic       y_ovf;
  logic       packet_valid;
  logic       sync_err;
  logic       timeout;

  modport master (
    output rx_data, rx_valid,
    input  x_axis, y_axis, buttons, x_ovf, y_ovf, packet_valid, sync_err, timeout
  );

  modport slave (
    input  rx_data, rx_valid,
    output x_axis, y_axis, buttons, x_ovf, y_ovf, packet_valid, sync_err, timeout
  );
endinterface

// File: rtl/ps2_packet_assembler.sv
// Assembles 3-byte PS/2 mouse packets; packet_valid 1 clk after the last byte, no backpressure (every rx_valid is consumed).
// Define PS2_OVF_SAT_EN to saturate an axis whose overflow flag is set; otherwise the raw {sign, byte} is output.
module ps2_packet_assembler #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  ps2_packet_assembler_if.slave bus
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2
  } state_t;

  // Header byte minus the always-one sync bit.
  typedef struct packed {
    logic       y_ovf;
    logic       x_ovf;
    logic       y_sign;
    logic       x_sign;
    logic [2:0] buttons;
  } hdr_t;

  typedef struct packed {
    logic [8:0] x_axis;
    logic [8:0] y_axis;
    logic [2:0] buttons;
    logic       x_ovf;
    logic       y_ovf;
  } pkt_t;

  state_t             state;
  state_t             state_nxt;
  logic [TIMER_W-1:0] timer;
  hdr_t               hdr;
  logic [7:0]         byte1;
  pkt_t               pkt_q;
  pkt_t               pkt_nxt;
  logic               packet_valid_q;
  logic               sync_err_q;
  logic               timeout_q;

  logic take_b0;
  logic take_b1;
  logic take_b2;
  logic hdr_bad;
  logic expire;
  logic timer_done;

  assign timer_done = (timer == TIMER_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_B0;
    end else begin
      state <= state_nxt;
    end
  end

  // A byte arriving on the expiry cycle takes priority over the timeout.
  always_comb begin
    state_nxt = state;
    take_b0   = 1'b0;
    take_b1   = 1'b0;
    take_b2   = 1'b0;
    hdr_bad   = 1'b0;
    expire    = 1'b0;
    case (state)
      WAIT_B0: begin
        if (bus.rx_valid) begin
          if (bus.rx_data[3]) begin
            take_b0   = 1'b1;
            state_nxt = WAIT_B1;
          end else begin
            hdr_bad = 1'b1;
          end
        end
      end
      WAIT_B1: begin
        if (bus.rx_valid) begin
          take_b1   = 1'b1;
          state_nxt = WAIT_B2;
        end else if (timer_done) begin
          expire    = 1'b1;
          state_nxt = WAIT_B0;
        end
      end
      WAIT_B2: begin
        if (bus.rx_valid) begin
          take_b2   = 1'b1;
          state_nxt = WAIT_B0;
        end else if (timer_done) begin
          expire    = 1'b1;
          state_nxt = WAIT_B0;
        end
      end
      default: begin
        state_nxt = WAIT_B0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (bus.rx_valid || (state == WAIT_B0) || expire) begin
      timer <= '0;
    end else begin
      timer <= timer + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr   <= '0;
      byte1 <= '0;
    end else begin
      if (take_b0) begin
        hdr <= '{y_ovf:   bus.rx_data[7],
                 x_ovf:   bus.rx_data[6],
                 y_sign:  bus.rx_data[5],
                 x_sign:  bus.rx_data[4],
                 buttons: bus.rx_data[2:0]};
      end
      if (take_b1) begin
        byte1 <= bus.rx_data;
      end
    end
  end

  // The third byte is used straight off the bus so the packet lands one cycle after it.
  always_comb begin
    pkt_nxt.x_axis  = {hdr.x_sign, byte1};
    pkt_nxt.y_axis  = {hdr.y_sign, bus.rx_data};
    pkt_nxt.buttons = hdr.buttons;
    pkt_nxt.x_ovf   = hdr.x_ovf;
    pkt_nxt.y_ovf   = hdr.y_ovf;
`ifdef PS2_OVF_SAT_EN
    if (hdr.x_ovf) begin
      pkt_nxt.x_axis = hdr.x_sign ? 9'h100 : 9'h0FF;
    end
    if (hdr.y_ovf) begin
      pkt_nxt.y_axis = hdr.y_sign ? 9'h100 : 9'h0FF;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_q          <= '0;
      packet_valid_q <= 1'b0;
      sync_err_q     <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      packet_valid_q <= take_b2;
      sync_err_q     <= hdr_bad;
      timeout_q      <= expire;
      if (take_b2) begin
        pkt_q <= pkt_nxt;
      end
    end
  end

  assign bus.x_axis       = pkt_q.x_axis;
  assign bus.y_axis       = pkt_q.y_axis;
  assign bus.buttons      = pkt_q.buttons;
  assign bus.x_ovf        = pkt_q.x_ovf;
  assign bus.y_ovf        = pkt_q.y_ovf;
  assign bus.packet_valid = packet_valid_q;
  assign bus.sync_err     = sync_err_q;
  assign bus.timeout      = timeout_q;

endmodule
